// File: rtl/midi_rx_pkg.sv
// Shared constants and types for the MIDI IN receiver.
package midi_rx_pkg;

    localparam int MIDI_RX_FIFO_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } MIDI_RX_ST_T;

    // Clocks per bit, rounded to nearest.
    function automatic int midi_rx_bit_clks(input int clk_hz, input int baud_hz);
        return (clk_hz + baud_hz / 2) / baud_hz;
    endfunction

endpackage

// File: rtl/midi_rx_fifo.sv
// Show-ahead receive FIFO for midi_rx (used when MIDI_RX_FIFO_EN is defined).
module midi_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  w_wr_nxt;
    logic [PTR_W-1:0]  w_rd_nxt;
    logic              r_empty;
    logic              r_full;
    logic              w_pop;
    logic              w_push;

    // A push into a full FIFO is accepted only when the head is leaving this cycle.
    assign w_pop    = pop_i && !r_empty;
    assign w_push   = push_i && (!r_full || w_pop);
    assign w_wr_nxt = r_wr + PTR_W'(w_push);
    assign w_rd_nxt = r_rd + PTR_W'(w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_empty <= (w_wr_nxt == w_rd_nxt);
            r_full  <= (w_wr_nxt[ADDR_W] != w_rd_nxt[ADDR_W]) &&
                       (w_wr_nxt[ADDR_W-1:0] == w_rd_nxt[ADDR_W-1:0]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr[ADDR_W-1:0]] <= data_i;
        end
    end

    assign data_o  = r_empty ? '0 : r_mem[r_rd[ADDR_W-1:0]];
    assign empty_o = r_empty;
    assign full_o  = r_full;

endmodule

// File: rtl/midi_rx.sv
// MIDI IN receiver: 8N1 deserializer with sticky overrun/framing flags.
// Define MIDI_RX_FIFO_EN to buffer bytes in midi_rx_fifo instead of one holding register.
//
// state   | meaning
// IDLE    | line idle, waiting for an armed falling edge
// START   | half-bit wait, confirm start bit at mid-bit
// DATA    | sampling DATA_W bits at mid-bit, LSB first
// STOP    | sample stop bit; push byte or flag framing error
module midi_rx
    import midi_rx_pkg::*;
#(
    parameter int CLK_HZ      = 180000000,
    parameter int BAUD_HZ     = 31250,
    parameter int DATA_W      = 8,
    parameter int SYNC_W      = 2,
    parameter int FIFO_ADDR_W = MIDI_RX_FIFO_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rdy_o,
    output logic              ovr_o,
    output logic              frm_o,
    input  logic              clr_i
);

    localparam int BIT_CLKS  = midi_rx_bit_clks(CLK_HZ, BAUD_HZ);
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CNT_W     = $clog2(BIT_CLKS);
    localparam int IDX_W     = $clog2(DATA_W + 1);

    logic [SYNC_W-1:0] r_sync;
    logic              w_rx_s;
    logic              r_armed;
    MIDI_RX_ST_T       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              w_tick;
    logic              w_push;
    logic              w_frm_set;
    logic              w_drop;
    logic              r_ovr;
    logic              r_frm;

    assign w_rx_s    = r_sync[SYNC_W-1];
    assign w_tick    = (r_cnt == '0);
    assign w_push    = (r_state == ST_STOP) && w_tick && w_rx_s;
    assign w_frm_set = (r_state == ST_STOP) && w_tick && !w_rx_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= rx_i;
            for (int i = 1; i < SYNC_W; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // r_armed is a falling-edge qualifier: a held-low break cannot re-trigger.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_armed <= 1'b1;
        end else begin
            r_armed <= w_rx_s;
            if (r_state != ST_IDLE && !w_tick) begin
                r_cnt <= r_cnt - 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s && r_armed) begin
                        r_cnt   <= CNT_W'(HALF_CLKS - 1);
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= CNT_W'(BIT_CLKS - 1);
                            r_idx   <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
                        r_cnt   <= CNT_W'(BIT_CLKS - 1);
                        r_idx   <= r_idx + IDX_W'(1);
                        if (r_idx == IDX_W'(DATA_W - 1)) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MIDI_RX_FIFO_EN
    logic w_full;
    logic w_empty;

    midi_rx_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (r_shift),
        .pop_i   (rd_i),
        .data_o  (data_o),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    assign rdy_o  = !w_empty;
    assign w_drop = w_push && w_full && !rd_i;
`else
    logic [DATA_W-1:0] r_data;
    logic              r_rdy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_rdy  <= 1'b0;
        end else if (w_push && (!r_rdy || rd_i)) begin
            r_data <= r_shift;
            r_rdy  <= 1'b1;
        end else if (rd_i) begin
            r_rdy <= 1'b0;
        end
    end

    assign data_o = r_data;
    assign rdy_o  = r_rdy;
    assign w_drop = w_push && r_rdy && !rd_i;
`endif

    // Setting beats clearing when both happen in one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovr <= 1'b0;
            r_frm <= 1'b0;
        end else begin
            if (w_drop)         r_ovr <= 1'b1;
            else if (clr_i)     r_ovr <= 1'b0;
            if (w_frm_set)      r_frm <= 1'b1;
            else if (clr_i)     r_frm <= 1'b0;
        end
    end

    assign ovr_o = r_ovr;
    assign frm_o = r_frm;

endmodule
